// File: rtl/bus_fifo_pkg.sv
// Shared widths and default depth for the bus width-converting FIFOs.
package bus_fifo_pkg;
    localparam int BUS_BEAT_W         = 64;
    localparam int BUS_BLOCK_W        = 128;
    localparam int BUS_FIFO_DEPTH_DEF = 16;
endpackage

// File: rtl/bus_pack_fifo_if.sv
// Beat-in / block-out signal bundle for bus_pack_fifo; flush exists only with BUS_PACK_FIFO_FLUSH_EN.
interface bus_pack_fifo_if
    import bus_fifo_pkg::*;
#(
    parameter int DEPTH = BUS_FIFO_DEPTH_DEF
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [BUS_BEAT_W-1:0]  write_data;
    logic                   write_en;
    logic                   read_en;
    logic [BUS_BLOCK_W-1:0] read_data;
    logic [CW-1:0]          fifo_count;
    logic                   fifo_full;
    logic                   fifo_half_full;
    logic                   fifo_empty;
`ifdef BUS_PACK_FIFO_FLUSH_EN
    logic                   flush;
`endif

    modport slave (
`ifdef BUS_PACK_FIFO_FLUSH_EN
        input  flush,
`endif
        input  write_data, write_en, read_en,
        output read_data, fifo_count, fifo_full, fifo_half_full, fifo_empty
    );

    modport master (
`ifdef BUS_PACK_FIFO_FLUSH_EN
        output flush,
`endif
        output write_data, write_en, read_en,
        input  read_data, fifo_count, fifo_full, fifo_half_full, fifo_empty
    );
endinterface

// File: rtl/bus_pack_fifo_mem.sv
// DEPTH x 64 beat storage: one write port, one registered dual-word read port.
// Latency: read block registered 1 cycle after rd_en. Backpressure: none, caller gates enables.
// rd_data resets to 0; the array itself is never cleared.
module bus_pack_fifo_mem
    import bus_fifo_pkg::*;
#(
    parameter int DEPTH = BUS_FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [AW-1:0]          wr_addr,
    input  logic [BUS_BEAT_W-1:0]  wr_data,
    input  logic                   rd_en,
    input  logic [AW-1:0]          rd_addr,
    output logic [BUS_BLOCK_W-1:0] rd_data
);
    logic [BUS_BEAT_W-1:0] mem [DEPTH];
    logic [AW-1:0]         rd_addr_hi;

    // rd_addr is always even, so the partner word never wraps.
    assign rd_addr_hi = rd_addr + AW'(1);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= {mem[rd_addr_hi], mem[rd_addr]};
        end
    end
endmodule

// File: rtl/bus_pack_fifo.sv
// 64->128 packing FIFO: pairs consecutive beats into blocks, oldest beat in the low half.
// Latency: write visible in flags next cycle; read_data registered 1 cycle after accepted read_en.
// Backpressure: writes dropped while fifo_full, reads dropped while fifo_empty. Optional flush: BUS_PACK_FIFO_FLUSH_EN.
module bus_pack_fifo
    import bus_fifo_pkg::*;
#(
    parameter int DEPTH = BUS_FIFO_DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    bus_pack_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  wr_fire;
    logic [BUS_BEAT_W-1:0] wr_dat;
    logic                  rd_acc;
    logic [CW-1:0]         count_nxt;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count < CW'(2));

    assign wr_acc = bus.write_en && !full;
    assign rd_acc = bus.read_en && !empty;

`ifdef BUS_PACK_FIFO_FLUSH_EN
    logic flush_acc;
    // A zero beat completes an odd trailing block; ignored when a real write is present.
    assign flush_acc = bus.flush && !bus.write_en && count[0] && !full;
    assign wr_fire   = wr_acc || flush_acc;
    assign wr_dat    = wr_acc ? bus.write_data : '0;
`else
    assign wr_fire   = wr_acc;
    assign wr_dat    = bus.write_data;
`endif

    assign count_nxt = count + {{(CW-1){1'b0}}, wr_fire} - {{(CW-2){1'b0}}, rd_acc, 1'b0};

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_fire) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + AW'(2);
            end
            count <= count_nxt;
        end
    end

    bus_pack_fifo_mem #(.DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_fire),
        .wr_addr (wr_ptr),
        .wr_data (wr_dat),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (bus.read_data)
    );

    assign bus.fifo_count     = count;
    assign bus.fifo_full      = full;
    assign bus.fifo_half_full = (count >= CW'(DEPTH / 2));
    assign bus.fifo_empty     = empty;
endmodule
